servo_position_sequencer: RTL and testbench

- Sequences the select input of the MG995 PWM generator (`pwm_servo_motor`).
- Drives a repeating angle sweep (0°, 90°, 180°, …), holding each position for a programmable dwell time.
- Arbitrates a manual override request against the sweep and parks the output at "off" (select 0) when idle.
- Sits between user controls (buttons/switches) and the PWM generator's select port.

---
 rtl/servo_position_sequencer.sv | 163 ++++++++++++++++
 tb/tb_servo_position_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/servo_position_sequencer.sv
// Position sequencer for the MG995 PWM generator: timed angle sweep with manual override.
// Define SERVO_SEQ_PINGPONG_EN for the 1,2,3,2 sweep table; otherwise the table is 1,2,3.
module servo_position_sequencer #(
  parameter int unsigned dwell_cycles_p = 50_000_000,
  parameter int unsigned cnt_width_p    = 32
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       Start_i,
  input  logic       Stop_i,
  input  logic       Manual_req_i,
  input  logic [1:0] Manual_sel_i,
  output logic [1:0] Sel_angle_o,
  output logic       Busy_o,
  output logic       Manual_o,
  output logic       Step_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_MANUAL = 2'd2
  } state_t;

  localparam logic [cnt_width_p-1:0] DWELL_LAST = cnt_width_p'(dwell_cycles_p - 1);
  localparam logic [cnt_width_p-1:0] CNT_ONE    = cnt_width_p'(1);
`ifdef SERVO_SEQ_PINGPONG_EN
  localparam logic [1:0] IDX_LAST = 2'd3;
`else
  localparam logic [1:0] IDX_LAST = 2'd2;
`endif

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_idx;
  logic [1:0]             w_idx_nxt;
  logic [cnt_width_p-1:0] r_cnt;
  logic [cnt_width_p-1:0] w_cnt_nxt;
  logic                   r_ret_sweep;
  logic                   w_ret_nxt;
  logic                   w_step_nxt;
  logic [1:0]             w_sel_nxt;
  logic                   w_busy_nxt;
  logic                   w_manual_nxt;
  logic                   w_manual_vld;
  logic                   w_dwell_done;
  logic                   w_start;

  // Index 3 is only reachable with the ping-pong table.
  function automatic logic [1:0] sweep_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    sweep_sel = 2'd1;
      2'd1:    sweep_sel = 2'd2;
      2'd2:    sweep_sel = 2'd3;
      default: sweep_sel = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    next_idx = (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;
  endfunction

  assign w_manual_vld = Manual_req_i && (Manual_sel_i != 2'd0);
  assign w_dwell_done = (r_cnt == DWELL_LAST);
  assign w_start      = Start_i && !Stop_i;

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_manual_vld) w_state_nxt = ST_MANUAL;
        else if (w_start) w_state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (Stop_i)            w_state_nxt = ST_IDLE;
        else if (w_manual_vld) w_state_nxt = ST_MANUAL;
      end
      ST_MANUAL: begin
        if (!w_manual_vld) w_state_nxt = r_ret_sweep ? ST_SWEEP : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sweep index, dwell counter and return mode follow the same priority as the state.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_cnt_nxt  = r_cnt;
    w_ret_nxt  = r_ret_sweep;
    w_step_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_manual_vld) begin
          w_ret_nxt = 1'b0;
        end else if (w_start) begin
          w_idx_nxt = 2'd0;
          w_cnt_nxt = '0;
        end
      end
      ST_SWEEP: begin
        if (Stop_i) begin
          w_cnt_nxt = '0;
        end else if (w_manual_vld) begin
          w_ret_nxt = 1'b1;
        end else if (w_dwell_done) begin
          w_cnt_nxt  = '0;
          w_idx_nxt  = next_idx(r_idx);
          w_step_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_MANUAL: begin
        if (!w_manual_vld) begin
          w_cnt_nxt = '0;
        end else if (Stop_i) begin
          w_ret_nxt = 1'b0;
        end else if (Start_i) begin
          w_ret_nxt = 1'b1;
          w_idx_nxt = 2'd0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_sel_nxt    = 2'd0;
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_manual_nxt = (w_state_nxt == ST_MANUAL);
    case (w_state_nxt)
      ST_SWEEP:  w_sel_nxt = sweep_sel(w_idx_nxt);
      ST_MANUAL: w_sel_nxt = Manual_sel_i;
      default:   w_sel_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      r_ret_sweep <= 1'b0;
      Sel_angle_o <= 2'd0;
      Busy_o      <= 1'b0;
      Manual_o    <= 1'b0;
      Step_o      <= 1'b0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ret_sweep <= w_ret_nxt;
      Sel_angle_o <= w_sel_nxt;
      Busy_o      <= w_busy_nxt;
      Manual_o    <= w_manual_nxt;
      Step_o      <= w_step_nxt;
    end
  end

endmodule

// File: tb/tb_servo_position_sequencer.sv
// Scoreboard bench for servo_position_sequencer: behavioural model feeds an expectation queue
// that a negedge monitor drains against the DUT outputs.
module tb_servo_position_sequencer;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, mreq = 1'b0;
  logic [1:0] msel = 2'd0;
  logic [1:0] sel;
  logic       busy, man, stp;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_e;

`ifdef SERVO_SEQ_PINGPONG_EN
  int tbl[$] = '{1, 2, 3, 2};
  int seq2[16] = '{1,1,1,1, 2,2,2,2, 3,3,3,3, 2,2,2,2};
`else
  int tbl[$] = '{1, 2, 3};
  int seq2[16] = '{1,1,1,1, 2,2,2,2, 3,3,3,3, 1,1,1,1};
`endif

  // Model: mode 0 idle, 1 sweep, 2 manual; held counts cycles spent at the current position.
  int m_mode, m_pos, m_held;
  bit m_ret;

  always #5 clk = ~clk;

  servo_position_sequencer #(.dwell_cycles_p(DWELL), .cnt_width_p(32)) dut (
    .Clk_i(clk), .Reset_i(rst_n), .Start_i(start), .Stop_i(stop),
    .Manual_req_i(mreq), .Manual_sel_i(msel),
    .Sel_angle_o(sel), .Busy_o(busy), .Manual_o(man), .Step_o(stp)
  );

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_held = 0; m_ret = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit r, input logic [1:0] ms,
                            output logic [4:0] e);
    bit vld, step;
    int esel;
    vld = r && (ms != 2'd0);
    step = 0;
    case (m_mode)
      0: if (vld) begin m_mode = 2; m_ret = 0; end
         else if (s && !p) begin m_mode = 1; m_pos = 0; m_held = 0; end
      1: if (p) m_mode = 0;
         else if (vld) begin m_mode = 2; m_ret = 1; end
         else begin
           m_held++;
           if (m_held == DWELL) begin
             m_held = 0; m_pos = (m_pos + 1) % tbl.size(); step = 1;
           end
         end
      default:
         if (!vld) begin m_mode = m_ret ? 1 : 0; m_held = 0; end
         else if (p) m_ret = 0;
         else if (s) begin m_ret = 1; m_pos = 0; end
    endcase
    esel = (m_mode == 0) ? 0 : (m_mode == 1) ? tbl[m_pos] : int'(ms);
    e = {esel[1:0], m_mode != 0, m_mode == 2, step};
  endtask

  task automatic drive(input bit s, input bit p, input bit r, input logic [1:0] ms);
    logic [4:0] e;
    @(negedge clk); #1;
    start = s; stop = p; mreq = r; msel = ms;
    model_step(s, p, r, ms, e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({sel, busy, man, stp} !== mon_e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got sel=%0d busy=%0b man=%0b step=%0b exp sel=%0d busy=%0b man=%0b step=%0b",
                 $time, sel, busy, man, stp, mon_e[4:3], mon_e[2], mon_e[1], mon_e[0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1;
    chk("reset_sel", sel, 0); chk("reset_busy", busy, 0);
    chk("reset_man", man, 0); chk("reset_step", stp, 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Start pulse: full sweep sequence with step pulses at each position change
    drive(1, 0, 0, 2'd0);
    @(posedge clk); #1;
    chk("t2_sel0", sel, seq2[0]); chk("t2_step0", stp, 0);
    for (int i = 1; i < 16; i++) begin
      drive(0, 0, 0, 2'd0);
      @(posedge clk); #1;
      chk($sformatf("t2_sel%0d", i), sel, seq2[i]);
      chk($sformatf("t2_step%0d", i), stp, (i % 4 == 0) ? 1 : 0);
    end

    // Asynchronous reset while sweeping at select 3
    drive(0, 1, 0, 2'd0);
    drive(1, 0, 0, 2'd0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 2'd0);
    @(posedge clk); #1;
    chk("t1_sel_before", sel, 3);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t1_sel", sel, 0); chk("t1_busy", busy, 0); chk("t1_step", stp, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 2'd0);
    @(posedge clk); #1;
    chk("t1_idle_busy", busy, 0);

    // Stop during second cycle of position 2, then restart
    drive(1, 0, 0, 2'd0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 2'd0);
    drive(0, 1, 0, 2'd0);
    drive(0, 0, 0, 2'd0);
    drive(1, 0, 0, 2'd0);
    @(posedge clk); #1;
    chk("t3_restart_sel", sel, 1);

    // Manual override at index 1, held 10 cycles, then resume
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 2'd0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 2'd3);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 2'd0);

    // Manual from IDLE with Start pulse, then with Stop pulse
    drive(0, 1, 0, 2'd0);
    drive(0, 0, 1, 2'd2);
    drive(1, 0, 1, 2'd2);
    drive(0, 0, 1, 2'd1);
    drive(0, 0, 0, 2'd0);
    @(posedge clk); #1;
    chk("t5_start_sel", sel, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 2'd0);
    drive(0, 1, 0, 2'd0);
    drive(0, 0, 1, 2'd3);
    drive(1, 0, 1, 2'd3);
    drive(0, 1, 1, 2'd3);
    drive(0, 0, 0, 2'd0);
    @(posedge clk); #1;
    chk("t5_stop_sel", sel, 0); chk("t5_stop_busy", busy, 0);

    // Invalid manual select and Start+Stop together in IDLE
    drive(0, 0, 1, 2'd0);
    drive(1, 1, 0, 2'd0);
    @(posedge clk); #1;
    chk("t6_sel", sel, 0); chk("t6_busy", busy, 0);

    // Randomized sequence
    begin
      bit r_req;
      logic [1:0] r_sel;
      r_req = 0; r_sel = 2'd1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) r_req = ~r_req;
        if ($urandom_range(0, 7) == 0) r_sel = 2'($urandom_range(0, 3));
        drive($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, r_req, r_sel);
      end
    end

    drive(0, 0, 0, 2'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
